fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues in-order requests to instruction memory over a valid/ready request channel and a fixed-order response channel.
- Buffers returned instructions in a small FIFO and presents {instr_IF, PC_IF, PCPlus4_IF, valid_IF} to the IF/ID register.
- Handles stalls from hazard control and PC redirects from taken branches/jumps, discarding wrong-path responses.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core-pipeline definitions used by the fetch stage and its instruction buffer.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush beats push/pop, push is legal when full if a pop happens too.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order requests,
// buffers responses and drops wrong-path data after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_IF,
  input  logic        pc_sel,
  input  logic [31:0] PCTarget,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] PCPlus4_IF,
  output logic        valid_IF
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic          run_q, run_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   retire_pc_q, retire_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_full, fifo_empty;
  logic          accept, push, pop;
  fetch_entry_t  push_entry, head;

  // run_q keeps the request channel quiet until the first edge after reset release
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = run_q && !pc_sel && (credit_used < DEPTH_L);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign valid_IF   = !fifo_empty;
  assign pop        = valid_IF && !stall_IF && !pc_sel;
  assign push       = imem_rsp_valid && !pc_sel && (drop_cnt_q == '0);
  assign push_entry = '{instr: imem_rsp_data, pc: retire_pc_q};

  assign instr_IF   = valid_IF ? head.instr : NOP_INSTR;
  assign PC_IF      = valid_IF ? head.pc : 32'h0;
  assign PCPlus4_IF = valid_IF ? head.pc + 32'd4 : 32'h0;

  always_comb begin
    run_d         = 1'b1;
    pc_d          = pc_q;
    retire_pc_d   = retire_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    if (pc_sel) begin
      // no accept on a redirect, so outstanding_d is exactly what is still owed
      pc_d        = PCTarget & ~32'd3;
      retire_pc_d = PCTarget & ~32'd3;
      drop_cnt_d  = outstanding_d;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) drop_cnt_d  = drop_cnt_q - 1'b1;
        else                  retire_pc_d = retire_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      retire_pc_q   <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      run_q         <= run_d;
      pc_q          <= pc_d;
      retire_pc_q   <= retire_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (pc_sel),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_push_room: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!fifo_full || pop));

endmodule
